// File: rtl/tracker_req_responder.sv
// tracker_req_responder
// NoC-side responder for tracker read requests. Accepts a two-flit request
// (header + body) on noc0, reads the tracker log RAM through a synchronous
// read port, packs EPF entries per flit (slot 0 in the MSBs) and returns one
// response packet to the requester.
//
// Optional feature: define TRACKER_RESP_CLAMP_EN to clamp RANGE requests to
// the entries actually logged (end_addr limited to log_wr_ptr - 1).
//
// Header layout (MSB first): dst_x, dst_y, dst_fbits[4], msg_len[22],
// msg_type[8], src_x, src_y, src_fbits[4], reserved.
// Request body layout (MSB first): req_type[2], start_addr, end_addr, reserved.
// META response flit: log_wr_ptr in the top TRACKER_ADDR_W+1 bits.
module tracker_req_responder #(
  parameter int                  NOC_DATA_W     = 512,
  parameter int                  TRACKER_ADDR_W = 10,
  parameter int                  ENTRY_W        = 128,
  parameter int                  XY_WIDTH       = 8,
  parameter logic [XY_WIDTH-1:0] SRC_X          = '0,
  parameter logic [XY_WIDTH-1:0] SRC_Y          = '0,
  parameter logic [3:0]          TRACKER_FBITS  = 4'hA
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      noc0_ctovr_resp_val,
  input  logic [NOC_DATA_W-1:0]     noc0_ctovr_resp_data,
  output logic                      noc0_ctovr_resp_rdy,
  output logic                      noc0_vrtoc_resp_val,
  output logic [NOC_DATA_W-1:0]     noc0_vrtoc_resp_data,
  input  logic                      noc0_vrtoc_resp_rdy,
  output logic                      log_rd_req_val,
  output logic [TRACKER_ADDR_W-1:0] log_rd_req_addr,
  input  logic [ENTRY_W-1:0]        log_rd_resp_data,
  input  logic [TRACKER_ADDR_W:0]   log_wr_ptr,
  output logic                      busy
);

  localparam int FBITS_W     = 4;
  localparam int MSG_LEN_W   = 22;
  localparam int MSG_TYPE_W  = 8;
  localparam int HDR_USED_W  = 4 * XY_WIDTH + 2 * FBITS_W + MSG_LEN_W + MSG_TYPE_W;
  localparam int BODY_USED_W = 2 + 2 * TRACKER_ADDR_W;
  localparam int EPF         = NOC_DATA_W / ENTRY_W;
  localparam int CNT_W       = $clog2(EPF + 1);
  localparam int SLOT_W      = (EPF > 1) ? $clog2(EPF) : 1;
  localparam int LEN_W       = TRACKER_ADDR_W + 1;

  localparam logic [LEN_W-1:0] EPF_LEN = LEN_W'(EPF);
  localparam logic [CNT_W-1:0] EPF_CNT = CNT_W'(EPF);

  typedef enum logic [1:0] {
    REQ_META  = 2'd0,
    REQ_RANGE = 2'd1
  } req_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_BODY,
    S_DECODE,
    S_TX_HDR,
    S_TX_META,
    S_RD,
    S_TX_DATA
  } state_e;

  typedef struct packed {
    logic [XY_WIDTH-1:0]              dst_x;
    logic [XY_WIDTH-1:0]              dst_y;
    logic [FBITS_W-1:0]               dst_fbits;
    logic [MSG_LEN_W-1:0]             msg_len;
    logic [MSG_TYPE_W-1:0]            msg_type;
    logic [XY_WIDTH-1:0]              src_x;
    logic [XY_WIDTH-1:0]              src_y;
    logic [FBITS_W-1:0]               src_fbits;
    logic [NOC_DATA_W-HDR_USED_W-1:0] rsvd;
  } noc_hdr_t;

  typedef struct packed {
    logic [1:0]                        req_type;
    logic [TRACKER_ADDR_W-1:0]         start_addr;
    logic [TRACKER_ADDR_W-1:0]         end_addr;
    logic [NOC_DATA_W-BODY_USED_W-1:0] rsvd;
  } req_body_t;

  state_e                    state_q, state_d;
  logic [XY_WIDTH-1:0]       req_x_q, req_y_q;
  logic [FBITS_W-1:0]        req_fbits_q;
  logic                      is_range_q;
  logic [TRACKER_ADDR_W-1:0] start_q, end_q;
  logic [LEN_W-1:0]          ptr_q;     // log_wr_ptr snapshot for META replies
  logic [LEN_W-1:0]          flits_q;   // body flits in the response (msg_len)
  logic [LEN_W-1:0]          rem_q;     // entries not yet packed into a flit
  logic [TRACKER_ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]          iss_q;     // reads issued for the current flit
  logic [CNT_W-1:0]          cap_q;     // entries captured for the current flit
  logic                      rd_pend_q; // a read was strobed last cycle
  logic [ENTRY_W-1:0]        slot_q [EPF];

  noc_hdr_t  in_hdr, out_hdr;
  req_body_t in_body;
  logic      in_fire, out_fire, rd_fire, last_cap, enter_rd;
  logic [CNT_W-1:0] flit_n;
  logic [LEN_W-1:0] start_ext, end_ext, n_entries, n_flits;
  logic             unused_bits;

  assign in_hdr  = noc_hdr_t'(noc0_ctovr_resp_data);
  assign in_body = req_body_t'(noc0_ctovr_resp_data);

  // Routing fields addressed to this tile and padding carry nothing we need.
  assign unused_bits = ^{in_hdr.dst_x, in_hdr.dst_y, in_hdr.dst_fbits, in_hdr.msg_len,
                         in_hdr.msg_type, in_hdr.rsvd, in_body.rsvd};

  assign in_fire  = noc0_ctovr_resp_val & noc0_ctovr_resp_rdy;
  assign out_fire = noc0_vrtoc_resp_val & noc0_vrtoc_resp_rdy;

  // Entries carried by the flit being assembled: a full flit or the tail.
  assign flit_n   = (rem_q < EPF_LEN) ? rem_q[CNT_W-1:0] : EPF_CNT;
  assign rd_fire  = (state_q == S_RD) && (iss_q < flit_n);
  assign last_cap = (state_q == S_RD) && rd_pend_q && (cap_q == flit_n - 1'b1);
  assign enter_rd = (state_q != S_RD) && (state_d == S_RD);

  // Decode the latched range into entry and flit counts (registered in S_DECODE).
  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    start_ext = {1'b0, start_q};
    end_ext   = {1'b0, end_q};
    n_entries = '0;
`ifdef TRACKER_RESP_CLAMP_EN
    // Nothing logged at or beyond start_addr means an empty, header-only reply.
    if ((log_wr_ptr != '0) && (start_ext < log_wr_ptr)) begin
      if (end_ext >= log_wr_ptr) end_ext = log_wr_ptr - 1'b1;
      if (end_ext >= start_ext) n_entries = end_ext - start_ext + 1'b1;
    end
`else
    if (end_ext >= start_ext) n_entries = end_ext - start_ext + 1'b1;
`endif
    n_flits = n_entries / EPF_LEN + LEN_W'((n_entries % EPF_LEN) != '0);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (in_fire) state_d = S_RX_BODY;
      S_RX_BODY: if (in_fire) state_d = S_DECODE;
      S_DECODE:  state_d = S_TX_HDR;
      S_TX_HDR: begin
        if (out_fire) begin
          if (!is_range_q)          state_d = S_TX_META;
          else if (flits_q == '0)   state_d = S_IDLE;
          else                      state_d = S_RD;
        end
      end
      S_TX_META: if (out_fire) state_d = S_IDLE;
      S_RD:      if (last_cap) state_d = S_TX_DATA;
      S_TX_DATA: if (out_fire) state_d = (rem_q != '0) ? S_RD : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Response header returned to the requester.
  always_comb begin
    out_hdr           = '0;
    out_hdr.dst_x     = req_x_q;
    out_hdr.dst_y     = req_y_q;
    out_hdr.dst_fbits = req_fbits_q;
    out_hdr.msg_len   = MSG_LEN_W'(flits_q);
    out_hdr.src_x     = SRC_X;
    out_hdr.src_y     = SRC_Y;
    out_hdr.src_fbits = TRACKER_FBITS;
  end

  // Port outputs; every driven flit comes straight from registers, so data holds while stalled.
  always_comb begin
    // Request side is closed while reset is asserted, whatever state the register holds.
    noc0_ctovr_resp_rdy  = !rst && ((state_q == S_IDLE) || (state_q == S_RX_BODY));
    noc0_vrtoc_resp_val  = (state_q == S_TX_HDR) || (state_q == S_TX_META) ||
                           (state_q == S_TX_DATA);
    noc0_vrtoc_resp_data = '0;
    unique case (state_q)
      S_TX_HDR:  noc0_vrtoc_resp_data = out_hdr;
      S_TX_META: noc0_vrtoc_resp_data[NOC_DATA_W-1 -: LEN_W] = ptr_q;
      S_TX_DATA: begin
        for (int k = 0; k < EPF; k++) begin
          noc0_vrtoc_resp_data[NOC_DATA_W-1-k*ENTRY_W -: ENTRY_W] = slot_q[k];
        end
      end
      default: noc0_vrtoc_resp_data = '0;
    endcase
    log_rd_req_val  = rd_fire;
    log_rd_req_addr = addr_q;
    busy            = (state_q != S_IDLE);
  end

  // State register, request latches and read sequencing counters.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_x_q     <= '0;
      req_y_q     <= '0;
      req_fbits_q <= '0;
      is_range_q  <= 1'b0;
      start_q     <= '0;
      end_q       <= '0;
      ptr_q       <= '0;
      flits_q     <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      iss_q       <= '0;
      cap_q       <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_q == S_IDLE) && in_fire) begin
        req_x_q     <= in_hdr.src_x;
        req_y_q     <= in_hdr.src_y;
        req_fbits_q <= in_hdr.src_fbits;
      end

      if ((state_q == S_RX_BODY) && in_fire) begin
        // Any type other than RANGE is answered as META.
        is_range_q <= (in_body.req_type == REQ_RANGE);
        start_q    <= in_body.start_addr;
        end_q      <= in_body.end_addr;
      end

      if (state_q == S_DECODE) begin
        ptr_q   <= log_wr_ptr;
        flits_q <= is_range_q ? n_flits : LEN_W'(1);
        rem_q   <= is_range_q ? n_entries : '0;
        addr_q  <= start_q;
      end

      if (enter_rd) begin
        iss_q     <= '0;
        cap_q     <= '0;
        rd_pend_q <= 1'b0;
      end else if (state_q == S_RD) begin
        rd_pend_q <= rd_fire;
        if (rd_fire) begin
          iss_q  <= iss_q + 1'b1;
          addr_q <= addr_q + 1'b1;
        end
        if (rd_pend_q) cap_q <= cap_q + 1'b1;
        if (last_cap)  rem_q <= rem_q - LEN_W'(flit_n);
      end
    end
  end

  // Slot buffer: cleared on entry to RD so a short tail flit pads with zeros.
  // NOTE: the slot buffer is pure datapath and is rewritten before it is ever presented, so it has no reset.
  always_ff @(posedge clk) begin
    if (enter_rd) begin
      for (int k = 0; k < EPF; k++) slot_q[k] <= '0;
    end else if ((state_q == S_RD) && rd_pend_q) begin
      slot_q[cap_q[SLOT_W-1:0]] <= log_rd_resp_data;
    end
  end

endmodule

// File: tb/tb_tracker_req_responder.sv
// Self-checking bench for tracker_req_responder: a reference model builds each
// expected response packet into a queue; a monitor pops and compares on every
// response handshake, checks data stability under backpressure and counts RAM
// read strobes per request.
module tb_tracker_req_responder;

  localparam int          NOC   = 512;
  localparam int          AW    = 10;
  localparam int          EW    = 128;
  localparam int          EPF   = NOC / EW;
  localparam logic [7:0]  MY_X  = 8'd1;
  localparam logic [7:0]  MY_Y  = 8'd2;
  localparam logic [3:0]  MY_FB = 4'hA;

  logic           clk;
  logic           rst;
  logic           ctovr_val;
  logic [NOC-1:0] ctovr_data;
  logic           ctovr_rdy;
  logic           vrtoc_val;
  logic [NOC-1:0] vrtoc_data;
  logic           vrtoc_rdy;
  logic           rd_val;
  logic [AW-1:0]  rd_addr;
  logic [EW-1:0]  rd_data;
  logic [AW:0]    wr_ptr;
  logic           busy;

  tracker_req_responder #(
    .NOC_DATA_W(NOC), .TRACKER_ADDR_W(AW), .ENTRY_W(EW), .XY_WIDTH(8),
    .SRC_X(MY_X), .SRC_Y(MY_Y), .TRACKER_FBITS(MY_FB)
  ) dut (
    .clk(clk), .rst(rst),
    .noc0_ctovr_resp_val(ctovr_val), .noc0_ctovr_resp_data(ctovr_data),
    .noc0_ctovr_resp_rdy(ctovr_rdy),
    .noc0_vrtoc_resp_val(vrtoc_val), .noc0_vrtoc_resp_data(vrtoc_data),
    .noc0_vrtoc_resp_rdy(vrtoc_rdy),
    .log_rd_req_val(rd_val), .log_rd_req_addr(rd_addr),
    .log_rd_resp_data(rd_data), .log_wr_ptr(wr_ptr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int             vectors = 0;
  int             errors  = 0;
  int             rd_strobes = 0;
  int             exp_strobes = 0;
  bit             rand_rdy = 0;
  logic [EW-1:0]  mem [1024];
  logic [NOC-1:0] exp_q [$];
  bit             stall_pend = 0;
  logic [NOC-1:0] stall_data;

  task automatic check(input string name, input logic [NOC-1:0] act, input logic [NOC-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NOC-1:0] rand512();
    logic [NOC-1:0] v;
    for (int i = 0; i < NOC / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Synchronous-read log RAM; returns junk on cycles that follow no strobe.
  always @(posedge clk) begin
    if (rd_val) rd_data <= mem[rd_addr];
    else        rd_data <= {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  // Monitor: compare every response handshake against the scoreboard queue.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 0;
    end else begin
      if (rd_val) rd_strobes++;
      if (stall_pend) begin
        check("stall hold val", {511'd0, vrtoc_val}, {511'd0, 1'b1});
        check("stall hold data", vrtoc_data, stall_data);
      end
      if (vrtoc_val && vrtoc_rdy) begin
        stall_pend = 0;
        if (exp_q.size() == 0) begin
          check("unexpected flit", vrtoc_data, '0);
          if (vrtoc_data == '0) begin
            errors++;
            $display("FAIL unexpected flit: got zero flit expected none");
          end
        end else begin
          check("resp flit", vrtoc_data, exp_q.pop_front());
        end
      end else if (vrtoc_val) begin
        stall_pend = 1;
        stall_data = vrtoc_data;
      end else begin
        stall_pend = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) vrtoc_rdy = ($urandom_range(0, 3) != 0);
  endtask

  function automatic logic [NOC-1:0] make_hdr(input logic [7:0] dx, input logic [7:0] dy,
                                              input logic [3:0] df, input int len);
    logic [NOC-1:0] h;
    h = '0;
    h[511:504] = dx;
    h[503:496] = dy;
    h[495:492] = df;
    h[491:470] = 22'(len);
    h[461:454] = MY_X;
    h[453:446] = MY_Y;
    h[445:442] = MY_FB;
    return h;
  endfunction

  // Reference model: the list of entries a request asks for, chopped into flits.
  task automatic push_expected(input logic [7:0] sx, input logic [7:0] sy, input logic [3:0] sf,
                               input logic [1:0] rt, input int st, input int en, input int wp);
    int hi, n, f, idx;
    logic [NOC-1:0] w;
    if (rt != 2'd1) begin
      exp_q.push_back(make_hdr(sx, sy, sf, 1));
      w = '0;
      w[511:501] = 11'(wp);
      exp_q.push_back(w);
      exp_strobes = 0;
      return;
    end
    hi = en;
`ifdef TRACKER_RESP_CLAMP_EN
    if (hi > wp - 1) hi = wp - 1;
`endif
    n = (hi >= st) ? hi - st + 1 : 0;
    f = (n + EPF - 1) / EPF;
    exp_q.push_back(make_hdr(sx, sy, sf, f));
    for (int j = 0; j < f; j++) begin
      w = '0;
      for (int k = 0; k < EPF; k++) begin
        idx = j * EPF + k;
        if (idx < n) w[NOC-1-k*EW -: EW] = mem[st + idx];
      end
      exp_q.push_back(w);
    end
    exp_strobes = n;
  endtask

  task automatic send_flit(input string name, input logic [NOC-1:0] d);
    logic acc;
    acc = 1'b0;
    ctovr_val  = 1'b1;
    ctovr_data = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = ctovr_rdy;
      tick();
    end
    ctovr_val  = 1'b0;
    ctovr_data = rand512();
    check({name, " accepted"}, {511'd0, acc}, {511'd0, 1'b1});
  endtask

  task automatic send_req(input logic [7:0] sx, input logic [7:0] sy, input logic [3:0] sf,
                          input logic [1:0] rt, input int st, input int en, input int wp);
    logic [NOC-1:0] h, b;
    wr_ptr = 11'(wp);
    push_expected(sx, sy, sf, rt, st, en, wp);
    rd_strobes = 0;
    h = rand512();
    h[461:454] = sx;
    h[453:446] = sy;
    h[445:442] = sf;
    b = rand512();
    b[511:510] = rt;
    b[509:500] = 10'(st);
    b[499:490] = 10'(en);
    send_flit("req hdr", h);
    send_flit("req body", b);
  endtask

  task automatic wait_done(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check({name, " completed"}, {511'd0, done}, {511'd0, 1'b1});
    check({name, " read strobes"}, NOC'(rd_strobes), NOC'(exp_strobes));
  endtask

  task automatic wait_val(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = vrtoc_val;
    end
    check({name, " valid"}, {511'd0, seen}, {511'd0, 1'b1});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, en, wp;
    logic [1:0] rt;
    logic seen;

    rst = 1'b1;
    ctovr_val = 1'b0;
    ctovr_data = '0;
    vrtoc_rdy = 1'b1;
    wr_ptr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = EW'(i);
    repeat (3) tick();

    // Reset values.
    check("reset req rdy", {511'd0, ctovr_rdy}, '0);
    check("reset resp val", {511'd0, vrtoc_val}, '0);
    check("reset rd val", {511'd0, rd_val}, '0);
    check("reset busy", {511'd0, busy}, '0);
    rst = 1'b0;
    tick();
    check("idle req rdy", {511'd0, ctovr_rdy}, {511'd0, 1'b1});

    // META from (2,3,9) with 37 entries logged.
    send_req(8'd2, 8'd3, 4'h9, 2'd0, 0, 0, 37);
    wait_done("meta", 200);

    // Identity log contents: ranges, a single entry, an inverted range.
    send_req(8'd4, 8'd5, 4'h1, 2'd1, 0, 7, 1024);
    wait_done("range 0..7", 200);
    send_req(8'd4, 8'd5, 4'h1, 2'd1, 5, 5, 1024);
    wait_done("range 5..5", 200);
    send_req(8'd4, 8'd5, 4'h1, 2'd1, 9, 4, 1024);
    wait_done("range 9..4", 200);
    send_req(8'd7, 8'd1, 4'h3, 2'd1, 1020, 1023, 1024);
    wait_done("range top", 200);
    send_req(8'd7, 8'd1, 4'h3, 2'd3, 10, 20, 512);
    wait_done("unknown type", 200);

    // Backpressure: stall the first data flit for 10 cycles.
    vrtoc_rdy = 1'b0;
    send_req(8'd6, 8'd6, 4'h2, 2'd1, 0, 7, 1024);
    wait_val("stall hdr");
    vrtoc_rdy = 1'b1;
    tick();
    vrtoc_rdy = 1'b0;
    wait_val("stall flit0");
    repeat (10) tick();
    vrtoc_rdy = 1'b1;
    wait_done("stall range", 200);

    // Range against a short log (clamped in one build, raw in the other).
    send_req(8'd3, 8'd2, 4'h5, 2'd1, 2, 100, 6);
    wait_done("clamp range", 400);

    // Randomised traffic with random downstream backpressure.
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    rand_rdy = 1;
    for (int t = 0; t < 40; t++) begin
      rt = ($urandom_range(0, 9) < 7) ? 2'd1 : 2'($urandom_range(0, 3));
      st = $urandom_range(0, 1023);
      case ($urandom_range(0, 7))
        0:       en = st - int'($urandom_range(1, 5));
        1:       en = 1023;
        default: en = st + int'($urandom_range(0, 20));
      endcase
      if (en < 0) en = 0;
      if (en > 1023) en = 1023;
      wp = $urandom_range(0, 1024);
      send_req(8'($urandom()), 8'($urandom()), 4'($urandom()), rt, st, en, wp);
      wait_done("random", 8000);
    end
    rand_rdy = 0;
    vrtoc_rdy = 1'b1;

    // Reset in the middle of a 3-flit response, then a clean META.
    for (int i = 0; i < 1024; i++) mem[i] = EW'(i);
    send_req(8'd2, 8'd2, 4'h4, 2'd1, 0, 9, 1024);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = rd_val;
    end
    check("reach RD", {511'd0, seen}, {511'd0, 1'b1});
    rst = 1'b1;
    tick();
    check("abort resp val", {511'd0, vrtoc_val}, '0);
    check("abort busy", {511'd0, busy}, '0);
    check("abort rd val", {511'd0, rd_val}, '0);
    exp_q.delete();
    rst = 1'b0;
    tick();
    send_req(8'd2, 8'd3, 4'h9, 2'd0, 0, 0, 37);
    wait_done("meta after reset", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tracker_req_responder.md
Name: tracker_req_responder

Overview:
- NoC-side responder for tracker read requests issued by the stats requester.
- Accepts a 2-flit request packet on noc0 (header + body carrying `req_type`/`start_addr`/`end_addr`) and reads the tracker log memory over a synchronous read port.
- Packs the log entries into NOC-width flits and returns one response packet to the requester's `src_x`/`src_y`/`src_fbits`.
- Sits between the noc0 router port of the tracker tile and the tracker log RAM.

Parameters:
- NOC_DATA_W, 512, NoC flit width (`NOC_DATA_WIDTH`).
- TRACKER_ADDR_W, 10, log entry address width.
- ENTRY_W, 128, log entry width; must divide NOC_DATA_W (EPF = NOC_DATA_W/ENTRY_W, default 4).
- SRC_X, 0, this tile's X coordinate (`XY_WIDTH` bits).
- SRC_Y, 0, this tile's Y coordinate.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- noc0_ctovr_resp_val  in  1  request flit valid
- noc0_ctovr_resp_data  in  NOC_DATA_W  request flit
- noc0_ctovr_resp_rdy  out  1  request flit accept
- noc0_vrtoc_resp_val  out  1  response flit valid
- noc0_vrtoc_resp_data  out  NOC_DATA_W  response flit
- noc0_vrtoc_resp_rdy  in  1  downstream accept
- log_rd_req_val  out  1  RAM read strobe
- log_rd_req_addr  out  TRACKER_ADDR_W  RAM read address
- log_rd_resp_data  in  ENTRY_W  RAM data, valid exactly 1 cycle after strobe
- log_wr_ptr  in  TRACKER_ADDR_W+1  number of valid logged entries
- busy  out  1  high whenever state != IDLE

Behaviour:
- Handshakes: a flit transfers only on val&rdy. `noc0_vrtoc_resp_val` holds and data stays stable until rdy.
- Reset values: `noc0_ctovr_resp_rdy`=0 during reset, 1 in IDLE/RX_BODY. `noc0_vrtoc_resp_val`=0, `log_rd_req_val`=0, `busy`=0, state=IDLE.
- States and transitions:
  - IDLE: accept header. Latch `src_x`/`src_y`/`src_fbits` from the standard beehive noc header. Go to RX_BODY.
  - RX_BODY: accept body. Latch `req_type` (`tracker_req_type`), `start_addr`, `end_addr` from the MSBs (same packed order as `requester_input` minus dst fields). Decode:
    - META request: response is 1 body flit carrying `log_wr_ptr` in the MSBs, zero elsewhere.
    - RANGE request: N = end_addr - start_addr + 1 entries (inclusive). If end_addr < start_addr, N = 0.
    - Body flits F = ceil(N/EPF).
    - Go to TX_HDR.
  - TX_HDR: drive header with dst = latched src, `msg_len` = F, src = SRC_X/SRC_Y, fbits = TRACKER_FBITS.
    - On handshake: META → TX_META; F=0 → IDLE; otherwise → RD.
  - TX_META: send the single flit, then IDLE.
  - RD: issue EPF consecutive reads (fewer on the last flit), one per cycle, address incrementing from start_addr.
    - Capture each `log_rd_resp_data` one cycle after its strobe into slot k. Slot 0 is the MSB entry.
    - Unfilled slots of the last flit are zero.
    - After the last capture → TX_DATA.
  - TX_DATA: present the packed flit and wait for rdy.
    - On handshake with remaining flits → RD; otherwise → IDLE.
- Reads never issue while a flit is waiting in TX_DATA, so there is no RAM backpressure path.
- Latency: header valid 2 cycles after body accept; each data flit valid EPF+1 cycles after the previous handshake.
- Arithmetic: address counter is TRACKER_ADDR_W bits; N and F are TRACKER_ADDR_W+1 bits; end_addr = 2^W - 1 is legal.
- No new request is accepted before returning to IDLE: in-order, one outstanding.
- Reset mid-packet aborts immediately: partial response is dropped, `val` deasserts the next cycle.
- Unknown `req_type`: treated as META.

Optional Feature:
- Macro: TRACKER_RESP_CLAMP_EN.
- Defined: in RANGE requests, end_addr is clamped to `log_wr_ptr` - 1. If `log_wr_ptr` = 0 or start_addr ≥ `log_wr_ptr`, then N = 0 (header-only response, `msg_len` 0).
- Undefined: the raw range is read regardless of `log_wr_ptr`.

Test Plan:
- META request from (2,3,fbits 0x9), `log_wr_ptr`=37 → header dst (2,3,0x9), `msg_len` 1; body MSBs = 37.
- RANGE 0..7, entry[i]=i, EPF=4 → `msg_len` 2; flit0 slots = 0,1,2,3; flit1 slots = 4,5,6,7.
- RANGE 5..5 → `msg_len` 1; slot0 = entry 5, slots 1-3 zero. RANGE 9..4 → header only, `msg_len` 0.
- Hold `noc0_vrtoc_resp_rdy`=0 for 10 cycles during flit0 of 0..7 → data stable; no extra `log_rd_req_val` pulses; second flit correct afterward.
- With TRACKER_RESP_CLAMP_EN, `log_wr_ptr`=6, RANGE 2..100 → `msg_len` 1, slots = entries 2..5. Without the macro → `msg_len` 25.
- Assert `rst` in RD of a 3-flit response → `val`=0 and `busy`=0 next cycle. A following META request completes normally.
